// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter/receiver pair: FSM state enum,
// default clock and baud constants, the clocks-per-bit helper and data width.
package uart_pkg;

    localparam int DEF_FCLK  = 100_000_000;
    localparam int DEF_FUART = 9600;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    function automatic int clks_per_bit(input int fclk, input int fuart);
        return fclk / fuart;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Receive-side output bundle of the UART receiver.
//   data_out   : last good byte, held until the next good frame
//   data_valid : one-cycle strobe when data_out is updated
//   frame_err  : one-cycle strobe when a stop bit is sampled low
//   busy       : receiver is inside a frame
// master = receiver (drives), slave = consumer (reads).
interface uart_rx_if;

    logic [uart_pkg::DATA_W-1:0] data_out;
    logic                        data_valid;
    logic                        frame_err;
    logic                        busy;

    modport master (output data_out, data_valid, frame_err, busy);
    modport slave  (input  data_out, data_valid, frame_err, busy);

endinterface

// File: rtl/uart_sync.sv
// uart_sync
// Two-flop synchronizer for the asynchronous Rx line plus a falling-edge
// detector. All flops reset to 1 (line idle level) so a reset never looks
// like a start edge.
//   clk_Rx : clock
//   reset  : synchronous, active-high
//   din    : asynchronous serial line
//   sync   : synchronized line level (2 flops deep)
//   fall   : previous synchronized level 1, current 0
module uart_sync (
    input  logic clk_Rx,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk_Rx) begin
        if (reset) begin
            {s1, s2, prev} <= 3'b111;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sync = s2;
    assign fall = prev & ~s2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. Samples the synchronized line at bit centres, shifts
// data LSB first, and reports each frame as a data_valid strobe (good stop
// bit) or a frame_err strobe (stop bit low).
//   clk_Rx : clock, rising edge
//   reset  : synchronous, active-high
//   Rx_in  : asynchronous serial line, idles high
//   rx_bus : uart_rx_if.master (data_out, data_valid, frame_err, busy)
// Optional macro UART_RX_MAJORITY_EN: each bit decision is the 2-of-3 vote of
// samples at centre-1, centre, centre+1, taken one cycle later than the
// single-sample build.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FCLK         = DEF_FCLK,
    parameter int FUART        = DEF_FUART,
    parameter int CLKS_PER_BIT = clks_per_bit(FCLK, FUART)
) (
    input  logic      clk_Rx,
    input  logic      reset,
    input  logic      Rx_in,
    uart_rx_if.master rx_bus
);

    localparam int BIT  = CLKS_PER_BIT;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam int BW   = $clog2(DATA_W);

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the centre+1 sample, so every decision slips one cycle.
    localparam int START_END = HALF;
`else
    localparam int START_END = HALF - 1;
`endif

    localparam logic [CW-1:0] CNT_START = CW'(START_END);
    localparam logic [CW-1:0] CNT_BIT   = CW'(BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    logic line_sync;
    logic line_fall;
    logic smp;

    uart_sync u_sync (
        .clk_Rx (clk_Rx),
        .reset  (reset),
        .din    (Rx_in),
        .sync   (line_sync),
        .fall   (line_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic h1;
    logic h2;

    always_ff @(posedge clk_Rx) begin
        if (reset) begin
            h1 <= 1'b1;
            h2 <= 1'b1;
        end else begin
            h1 <= line_sync;
            h2 <= h1;
        end
    end

    assign smp = (h2 & h1) | (h2 & line_sync) | (h1 & line_sync);
`else
    assign smp = line_sync;
`endif

    uart_state_t       state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              busy_q;

    always_ff @(posedge clk_Rx) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (line_fall) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_START) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        if (smp) begin
                            // line back high at mid start bit: false start
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT) begin
                        cnt <= '0;
                        sr  <= {smp, sr[DATA_W-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_BIT) begin
                        // Return straight to IDLE: only a fresh falling edge
                        // restarts, so a held-low line cannot retrigger.
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (smp) begin
                            data_q  <= sr;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.data_out   = data_q;
    assign rx_bus.data_valid = valid_q;
    assign rx_bus.frame_err  = ferr_q;
    assign rx_bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Bench for uart_rx with FCLK=16, FUART=1 (BIT=16, HALF=8). The line level
// and reset seen at every rising edge are logged; a reference receiver then
// derives the expected output events from that log by bit-centre arithmetic
// and they are compared with the events the DUT produced. Directed checks
// cover reset values, latency, back-to-back spacing, glitch rejection,
// framing error, reset mid-frame and the centre-glitch frame.
module tb_uart_rx;

    localparam int BIT  = 16;
    localparam int HALF = 8;
    localparam int MAXE = 4096;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct {
        int         t;
        bit         kind;   // 0 = data_valid, 1 = frame_err
        logic [7:0] b;
    } ev_t;

    logic clk_Rx = 1'b0;
    logic reset  = 1'b1;
    logic Rx_in  = 1'b1;

    always #5 clk_Rx = ~clk_Rx;

    uart_rx_if bus ();

    uart_rx #(.FCLK(16), .FUART(1)) dut (
        .clk_Rx (clk_Rx),
        .reset  (reset),
        .Rx_in  (Rx_in),
        .rx_bus (bus)
    );

    logic r_log   [0:MAXE-1];
    logic rst_log [0:MAXE-1];
    int   edge_n   = 0;
    int   both_cnt = 0;
    ev_t  dut_q [$];
    ev_t  exp_q [$];
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk_Rx) begin
        if (edge_n < MAXE - 1) begin
            r_log[edge_n + 1]   <= Rx_in;
            rst_log[edge_n + 1] <= reset;
        end
        edge_n <= edge_n + 1;
    end

    always @(negedge clk_Rx) begin
        if (bus.data_valid === 1'b1)
            dut_q.push_back('{t: edge_n, kind: 1'b0, b: bus.data_out});
        if (bus.frame_err === 1'b1)
            dut_q.push_back('{t: edge_n, kind: 1'b1, b: 8'h00});
        if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1)
            both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input logic v, input bit glitch);
        for (int j = 0; j < BIT; j++) begin
            Rx_in = (glitch && j == HALF) ? ~v : v;
            @(negedge clk_Rx);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch);
        drive_bit(1'b0, glitch);
        for (int k = 0; k < 8; k++) drive_bit(b[k], glitch);
        drive_bit(stop_v, glitch);
    endtask

    task automatic idle(input int n);
        Rx_in = 1'b1;
        repeat (n) @(negedge clk_Rx);
    endtask

    // ---------------- reference receiver ----------------
    // Synchronized level seen by the receiver at edge e: the pin value from
    // two edges earlier, forced high if either synchronizer stage was reset.
    function automatic logic s2b(input int e);
        if (e - 2 < 1) return 1'b1;
        if (rst_log[e - 1] || rst_log[e - 2]) return 1'b1;
        return r_log[e - 2];
    endfunction

    function automatic logic prevb(input int e);
        if (e - 1 < 1) return 1'b1;
        if (rst_log[e - 1]) return 1'b1;
        return s2b(e - 1);
    endfunction

    function automatic logic samp(input int d);
        logic a, b, c;
        a = s2b(d - 2);
        b = s2b(d - 1);
        c = s2b(d);
        if (MAJ != 0) return (a & b) | (a & c) | (b & c);
        return c;
    endfunction

    function automatic int first_rst(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (rst_log[i]) return i;
        return 0;
    endfunction

    task automatic run_model(input int last);
        int e;
        e = 1;
        while (e <= last) begin
            if (!rst_log[e] && prevb(e) == 1'b1 && s2b(e) == 1'b0) begin
                int ds;
                int dstop;
                int rf;
                logic [7:0] b;
                ds    = e + HALF + MAJ;
                dstop = ds + 9 * BIT;
                if (dstop > last) break;
                rf = first_rst(e + 1, dstop);
                if (rf != 0 && rf <= ds) begin
                    e = rf + 1;
                    continue;
                end
                if (samp(ds) == 1'b1) begin
                    e = ds + 1;
                    continue;
                end
                if (rf != 0) begin
                    e = rf + 1;
                    continue;
                end
                b = 8'h00;
                for (int k = 0; k < 8; k++) b[k] = samp(ds + (k + 1) * BIT);
                if (samp(dstop) == 1'b1)
                    exp_q.push_back('{t: dstop, kind: 1'b0, b: b});
                else
                    exp_q.push_back('{t: dstop, kind: 1'b1, b: 8'h00});
                e = dstop + 1;
            end else begin
                e++;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0;
        int t0;
        int bc;
        logic [7:0] rb;
        logic       rs;

        reset = 1'b1;
        Rx_in = 1'b1;
        repeat (3) @(negedge clk_Rx);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);
        chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        idle(20);

        // single frame 0x72: latency from the falling edge
        n0 = dut_q.size();
        t0 = edge_n;
        send_frame(8'h72, 1'b1, 1'b0);
        idle(10);
        chk("f72_events", 32'(dut_q.size() - n0), 32'd1);
        if (dut_q.size() > n0) begin
            chk("f72_kind", 32'(dut_q[n0].kind), 32'd0);
            chk("f72_byte", 32'(dut_q[n0].b), 32'h72);
            chk("f72_latency", 32'(dut_q[n0].t - t0), 32'(3 + HALF + 9 * BIT + MAJ));
        end
        chk("f72_data_out", 32'(bus.data_out), 32'h72);
        idle(10);

        // back-to-back 0xA5, 0x3C with no idle bit between
        n0 = dut_q.size();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        chk("b2b_events", 32'(dut_q.size() - n0), 32'd2);
        if (dut_q.size() > n0 + 1) begin
            chk("b2b_byte0", 32'(dut_q[n0].b), 32'hA5);
            chk("b2b_byte1", 32'(dut_q[n0 + 1].b), 32'h3C);
            chk("b2b_spacing", 32'(dut_q[n0 + 1].t - dut_q[n0].t), 32'd160);
        end
        idle(10);

        // 4-cycle glitch: false start, no output, busy for half a bit
        n0 = dut_q.size();
        bc = 0;
        for (int i = 0; i < 34; i++) begin
            Rx_in = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk_Rx);
            if (bus.busy === 1'b1) bc++;
        end
        chk("glitch_busy_cycles", 32'(bc), 32'(HALF + MAJ));
        chk("glitch_events", 32'(dut_q.size() - n0), 32'd0);
        chk("glitch_data_out", 32'(bus.data_out), 32'h3C);

        // 0x55 with stop low, then a 500-cycle break
        n0 = dut_q.size();
        send_frame(8'h55, 1'b0, 1'b0);
        Rx_in = 1'b0;
        repeat (500) @(negedge clk_Rx);
        idle(40);
        chk("ferr_events", 32'(dut_q.size() - n0), 32'd1);
        if (dut_q.size() > n0) chk("ferr_kind", 32'(dut_q[n0].kind), 32'd1);
        chk("ferr_data_out_held", 32'(bus.data_out), 32'h3C);

        // reset in the middle of data bit 4 of 0xFF, then 0x81
        n0 = dut_q.size();
        drive_bit(1'b0, 1'b0);
        repeat (4) drive_bit(1'b1, 1'b0);
        repeat (8) @(negedge clk_Rx);
        reset = 1'b1;
        @(negedge clk_Rx);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk_Rx);
        reset = 1'b0;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);
        chk("midrst_events", 32'(dut_q.size() - n0), 32'd1);
        if (dut_q.size() > n0) chk("midrst_byte", 32'(dut_q[n0].b), 32'h81);
        chk("midrst_data_out", 32'(bus.data_out), 32'h81);

        // 0x0F with a one-cycle inverted glitch at every bit centre
        send_frame(8'h0F, 1'b1, 1'b1);
        idle(100);
`ifdef UART_RX_MAJORITY_EN
        chk("cglitch_data_out", 32'(bus.data_out), 32'h0F);
`else
        chk("cglitch_corrupt", 32'(bus.data_out !== 8'h0F), 32'd1);
`endif

        // random frames, occasional bad stop bit, random gaps
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 1'b0);
            idle($urandom_range(0, 20));
        end
        idle(200);

        // reference comparison over the whole run
        run_model(edge_n);
        chk("ev_count", 32'(dut_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
            chk($sformatf("ev%0d_time", i), 32'(dut_q[i].t), 32'(exp_q[i].t));
            chk($sformatf("ev%0d_kind", i), 32'(dut_q[i].kind), 32'(exp_q[i].kind));
            chk($sformatf("ev%0d_byte", i), 32'(dut_q[i].b), 32'(exp_q[i].b));
        end
        chk("valid_and_ferr_together", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
